// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file port controller.
// Contents: controller state enumeration, default register count,
// address/data widths and the default debug starvation limit.
package regfile_ctrl_pkg;

  localparam int N_REGS_DEF     = 32;
  localparam int AW             = 5;
  localparam int DW             = 32;
  localparam int STARVE_LIM_DEF = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rfc_starve_timer.sv
// Debug starvation timer: counts RUN cycles in which a debug request is
// pending but not granted, and raises a stall flag once the limit is hit.
// Ports: clk_50/rst (sync, active-high); run, dbg_req, grant, dbg_ack in;
// stall out (registered).
module rfc_starve_timer
  import regfile_ctrl_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic clk_50,
  input  logic rst,
  input  logic run,
  input  logic dbg_req,
  input  logic grant,
  input  logic dbg_ack,
  output logic stall
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [SW-1:0] starve_cnt;
  logic          ungranted;

  assign ungranted = run && dbg_req && !grant;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      starve_cnt <= '0;
      stall      <= 1'b0;
    end else begin
      if (!ungranted)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIM))
        starve_cnt <= starve_cnt + SW'(1);

      // Set in the same edge the count reaches the limit so the stall is
      // visible the cycle right after the last ungranted one. Released the
      // cycle after the debug write is acknowledged.
      if (dbg_ack)
        stall <= 1'b0;
      else if (ungranted && (starve_cnt >= SW'(STARVE_LIM - 1)))
        stall <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file write-port controller: loads all registers from an init
// ROM after reset, then arbitrates CPU writeback against debug writes.
// Ports: clk_50/rst; rom_addr/rom_data (1-cycle ROM); cpu_we/wr/wd;
// dbg_req/addr/data/ack; rf_we/wr/wd; cpu_stall, init_done, err_drop.
module regfile_port_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int N_REGS     = N_REGS_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic          clk_50,
  input  logic          rst,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_wr,
  input  logic [DW-1:0] cpu_wd,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_data,
  output logic          dbg_ack,
  output logic          rf_we,
  output logic [AW-1:0] rf_wr,
  output logic [DW-1:0] rf_wd,
  output logic          cpu_stall,
  output logic          init_done,
  output logic          err_drop
);

  // One extra bit so the counter can reach N_REGS: the last ROM word is
  // written one cycle after its address was issued.
  localparam int CW = AW + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          in_run;
  logic          stall;
  logic          grant_cpu;
  logic          grant_dbg;
  logic          drop;
  logic [AW-1:0] init_wr;

  assign in_run    = (state == RUN);
  assign init_done = in_run;
  assign cpu_stall = !in_run || stall;
  assign rom_addr  = cnt[AW-1:0];
  assign init_wr   = AW'(cnt - CW'(1));

  // CPU wins unless stalled; a debug grant is never issued in the ack cycle.
  assign grant_cpu = in_run && !stall && cpu_we;
  assign grant_dbg = in_run && dbg_req && !dbg_ack && (stall || !cpu_we);
  assign drop      = in_run && stall && cpu_we;

  always_comb begin
    rf_we = 1'b0;
    rf_wr = '0;
    rf_wd = '0;
    if (!in_run) begin
      // Data for the address issued last cycle is arriving now.
      if (cnt != '0) begin
        rf_we = 1'b1;
        rf_wr = init_wr;
        rf_wd = (init_wr == '0) ? '0 : rom_data;
      end
    end else if (grant_cpu) begin
      rf_we = (cpu_wr != '0);
      rf_wr = cpu_wr;
      rf_wd = cpu_wd;
    end else if (grant_dbg) begin
      rf_we = (dbg_addr != '0);
      rf_wr = dbg_addr;
      rf_wd = dbg_data;
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= '0;
      dbg_ack  <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      dbg_ack  <= grant_dbg;
      err_drop <= drop;
      case (state)
        INIT: begin
          if (cnt == CW'(N_REGS)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  rfc_starve_timer #(
    .STARVE_LIM(STARVE_LIM)
  ) u_starve (
    .clk_50 (clk_50),
    .rst    (rst),
    .run    (in_run),
    .dbg_req(dbg_req),
    .grant  (grant_dbg),
    .dbg_ack(dbg_ack),
    .stall  (stall)
  );

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a registered init ROM model
// (word = 0xA5000000 + addr). Inputs change 1 time unit after the rising
// edge; outputs are compared on the falling edge of the same cycle.
module tb_regfile_port_ctrl;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        cpu_we;
  logic [4:0]  cpu_wr;
  logic [31:0] cpu_wd;
  logic        dbg_req;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ack;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        cpu_stall;
  logic        init_done;
  logic        err_drop;

  int n_chk = 0;
  int n_bad = 0;

  regfile_port_ctrl dut (
    .clk_50   (clk_50),
    .rst      (rst),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .cpu_we   (cpu_we),
    .cpu_wr   (cpu_wr),
    .cpu_wd   (cpu_wd),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .dbg_ack  (dbg_ack),
    .rf_we    (rf_we),
    .rf_wr    (rf_wr),
    .rf_wd    (rf_wd),
    .cpu_stall(cpu_stall),
    .init_done(init_done),
    .err_drop (err_drop)
  );

  always #10 clk_50 = ~clk_50;

  always_ff @(posedge clk_50)
    rom_data <= 32'hA500_0000 + {27'd0, rom_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_50);
  endtask

  task automatic chk_reset_state();
    chk("rst_done",  init_done, 0);
    chk("rst_stall", cpu_stall, 1);
    chk("rst_ack",   dbg_ack,   0);
    chk("rst_drop",  err_drop,  0);
    chk("rst_we",    rf_we,     0);
    chk("rst_rom",   rom_addr,  0);
  endtask

  // Cycles 1..32 after reset release: one ROM-sourced write per cycle.
  task automatic init_seq();
    logic [31:0] exp_wd;
    for (int k = 1; k <= 32; k++) begin
      tick();
      mid();
      exp_wd = (k == 1) ? 32'd0 : 32'hA500_0000 + k - 1;
      chk("init_we",    rf_we,     1);
      chk("init_wr",    rf_wr,     k - 1);
      chk("init_wd",    rf_wd,     exp_wd);
      chk("init_stall", cpu_stall, 1);
      chk("init_done",  init_done, 0);
      chk("init_ack",   dbg_ack,   0);
      chk("init_drop",  err_drop,  0);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_we = 1'b0; cpu_wr = '0; cpu_wd = '0;
    dbg_req = 1'b0; dbg_addr = '0; dbg_data = '0;
    @(posedge clk_50);
    tick();
    rst = 1'b0;
    mid();
    chk_reset_state();
    init_seq();
    tick(); mid();
    chk("run_done",  init_done, 1);
    chk("run_stall", cpu_stall, 0);
    chk("run_idle",  rf_we,     0);

    // Plain CPU writeback, zero latency.
    tick(); cpu_we = 1; cpu_wr = 5; cpu_wd = 32'h1234;
    mid();
    chk("cpu_we", rf_we, 1); chk("cpu_wr", rf_wr, 5); chk("cpu_wd", rf_wd, 32'h1234);

    // CPU and debug together: CPU first, then debug, then ack.
    tick(); cpu_wr = 3; cpu_wd = 32'h55; dbg_req = 1; dbg_addr = 7; dbg_data = 32'hBEEF;
    mid();
    chk("both_wr", rf_wr, 3); chk("both_wd", rf_wd, 32'h55); chk("both_ack", dbg_ack, 0);
    tick(); cpu_we = 0;
    mid();
    chk("dbg_we", rf_we, 1); chk("dbg_wr", rf_wr, 7); chk("dbg_wd", rf_wd, 32'hBEEF);
    chk("dbg_ack_early", dbg_ack, 0);
    tick(); mid();
    chk("dbg_ack", dbg_ack, 1); chk("dbg_no_regrant", rf_we, 0);
    tick(); dbg_req = 0;
    mid();
    chk("dbg_ack_pulse", dbg_ack, 0);

    // Starvation: CPU hogs the port while debug waits.
    tick(); cpu_we = 1; cpu_wr = 9; cpu_wd = 32'h99; dbg_req = 1; dbg_addr = 7; dbg_data = 32'hBEEF;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("starve_stall", cpu_stall, 0);
      chk("starve_wr", rf_wr, 9);
      chk("starve_ack", dbg_ack, 0);
      tick();
    end
    mid();
    chk("stall_on", cpu_stall, 1);
    chk("stall_dbg_we", rf_we, 1); chk("stall_dbg_wr", rf_wr, 7); chk("stall_dbg_wd", rf_wd, 32'hBEEF);
    chk("stall_drop0", err_drop, 0);
    tick(); mid();
    chk("stall_ack", dbg_ack, 1); chk("stall_hold", cpu_stall, 1);
    chk("stall_drop1", err_drop, 1); chk("stall_no_we", rf_we, 0);
    tick(); dbg_req = 0;
    mid();
    chk("stall_off", cpu_stall, 0); chk("stall_drop2", err_drop, 1);
    chk("resume_we", rf_we, 1); chk("resume_wr", rf_wr, 9); chk("resume_ack", dbg_ack, 0);
    tick(); cpu_we = 0;
    mid();
    chk("drop_clear", err_drop, 0);

    // Register 0 writes suppressed; debug still acknowledged.
    tick(); cpu_we = 1; cpu_wr = 0; cpu_wd = 32'hDEAD; dbg_req = 1; dbg_addr = 0; dbg_data = 32'hF00D;
    mid();
    chk("r0_cpu_we", rf_we, 0);
    tick(); cpu_we = 0;
    mid();
    chk("r0_dbg_we", rf_we, 0); chk("r0_ack_early", dbg_ack, 0);
    tick(); mid();
    chk("r0_ack", dbg_ack, 1);
    tick(); dbg_req = 0;
    mid();
    chk("r0_ack_pulse", dbg_ack, 0);

    // Reset during a debug grant discards the ack.
    tick(); rst = 1; dbg_req = 1; dbg_addr = 7; dbg_data = 32'hBEEF;
    mid();
    chk("pre_rst_grant", rf_wr, 7);
    tick(); rst = 0; cpu_we = 1; cpu_wr = 4; cpu_wd = 32'h44;
    mid();
    chk_reset_state();
    for (int k = 1; k <= 11; k++) begin
      tick(); mid();
      chk("init1_ack", dbg_ack, 0);
      chk("init1_drop", err_drop, 0);
    end
    // Reset again at cnt=12 with the debug request still pending.
    tick(); rst = 1;
    mid();
    chk("cnt12_rom", rom_addr, 12); chk("cnt12_wr", rf_wr, 11);
    tick(); rst = 0;
    mid();
    chk_reset_state();
    init_seq();
    tick(); cpu_we = 0;
    mid();
    chk("rerun_done", init_done, 1); chk("rerun_stall", cpu_stall, 0);
    chk("rerun_drop", err_drop, 0);
    chk("rerun_dbg_we", rf_we, 1); chk("rerun_dbg_wr", rf_wr, 7); chk("rerun_dbg_wd", rf_wd, 32'hBEEF);
    tick(); mid();
    chk("rerun_ack", dbg_ack, 1);
    tick(); dbg_req = 0;
    mid();
    chk("rerun_ack_pulse", dbg_ack, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
REGFILE_PORT_CTRL -- requirements
Module: regfile_port_ctrl

Interface
REQ-001 Parameter: N_REGS, 32, number of registers initialised; fixes address width at 5 bits.
REQ-002 Parameter: STARVE_LIM, 4, consecutive ungranted debug-request cycles before the CPU is stalled.
REQ-003 clk_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rom_addr  out  5  init ROM address; ROM returns data one cycle later.
REQ-006 rom_data  in  32  init ROM read data.
REQ-007 cpu_we  in  1  CPU writeback enable.
REQ-008 cpu_wr  in  5  CPU writeback address.
REQ-009 cpu_wd  in  32  CPU writeback data.
REQ-010 dbg_req  in  1  debug write request; held until dbg_ack.
REQ-011 dbg_addr  in  5  debug write address; stable while dbg_req=1.
REQ-012 dbg_data  in  32  debug write data; stable while dbg_req=1.
REQ-013 dbg_ack  out  1  one-cycle pulse: debug write performed.
REQ-014 rf_we  out  1  register file write enable.
REQ-015 rf_wr  out  5  register file write address.
REQ-016 rf_wd  out  32  register file write data.
REQ-017 cpu_stall  out  1  CPU must hold and drive cpu_we=0.
REQ-018 init_done  out  1  initialisation complete.
REQ-019 err_drop  out  1  one-cycle pulse: CPU write dropped while stalled.

Function
REQ-020 States SHALL be INIT, RUN; rst forces INIT with counter cnt=0.
REQ-021 INIT SHALL drive rom_addr=cnt in cycle k and, in cycle k+1, rf_we=1, rf_wr=k, rf_wd=rom_data; cnt increments each cycle.
REQ-022 Write to register 0 during INIT SHALL use rf_wd=0 regardless of rom_data.
REQ-023 After the write of address 31 (cycle 32 after rst release), the next cycle SHALL be RUN with init_done=1, cpu_stall=0.
REQ-024 In INIT, cpu_stall=1, cpu_we SHALL be ignored without err_drop, and dbg_req SHALL stay pending without counting toward starvation.
REQ-025 In RUN, rf_we/rf_wr/rf_wd SHALL be combinational from current inputs and state (zero added latency).
REQ-026 RUN priority: cpu_stall=0 -> CPU write if cpu_we=1, else debug write if dbg_req=1 and dbg_ack=0; cpu_stall=1 -> debug write first.
REQ-027 Any write (CPU or debug) addressed to register 0 in RUN SHALL be suppressed (rf_we=0); a debug request to address 0 still receives dbg_ack.
REQ-028 dbg_ack SHALL be registered, high exactly the cycle after the debug grant; no grant SHALL occur in a cycle with dbg_ack=1.
REQ-029 Starvation counter SHALL count RUN cycles with dbg_req=1 and no grant, clear on grant or dbg_req=0, saturate at STARVE_LIM.
REQ-030 When the counter reaches STARVE_LIM, cpu_stall SHALL assert from the next cycle until the cycle after dbg_ack.
REQ-031 cpu_we=1 during cpu_stall=1 in RUN SHALL be dropped and pulse err_drop (registered, next cycle).
REQ-032 Simultaneous cpu_we and dbg_req with cpu_stall=0 SHALL grant CPU; debug waits.

Reset
REQ-033 rst=1 in any state SHALL return to INIT, cnt=0, counter=0, discard pending debug grant, and next cycle drive init_done=0, cpu_stall=1, dbg_ack=0, err_drop=0, rf_we=0, rom_addr=0.

Structure
REQ-034 Package regfile_ctrl_pkg SHALL hold the state enumeration, N_REGS default, address width 5, and STARVE_LIM default.
REQ-035 Starvation counter and stall flag SHALL be one sub-module, rfc_starve_timer; remaining logic in regfile_port_ctrl.

Verification
REQ-036 ROM word = 0xA5000000+addr, rst 1 cycle -> writes addr 1..31 with 0xA5000001..0xA500001F, addr 0 with 0, init_done rises at cycle 33.
REQ-037 RUN, cpu_we=1 wr=5 wd=0x1234 -> same-cycle rf_we=1 rf_wr=5 rf_wd=0x1234.
REQ-038 RUN, cpu_we and dbg_req(addr 7, 0xBEEF) same cycle, cpu_we drops next cycle -> CPU written first, debug written next cycle, dbg_ack the cycle after.
REQ-039 cpu_we held high, dbg_req held -> cpu_stall after 4 ungranted cycles, debug write 0xBEEF to reg 7, dbg_ack, cpu_stall deasserts; cpu_we during stall pulses err_drop.
REQ-040 rst asserted at init cnt=12 with dbg_req pending -> restart from address 0, no dbg_ack, full 33-cycle init repeats.
REQ-041 RUN, cpu_we wr=0 and dbg_req addr 0 -> rf_we=0 both, dbg_ack still pulses.
